me_sad_search_engine: RTL and testbench

//  Parametrised full-search block-matching motion estimator, successor to the fixed 16x16 / 31x31 engine.

---
 rtl/me_sad_search_engine_if.sv | 34 +++
 rtl/me_sad_search_engine.sv | 229 ++++++++++++++++++++++
 tb/tb_me_sad_search_engine.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/me_sad_search_engine_if.sv
// Handshake and memory-port bundle for me_sad_search_engine.
// The master side drives start and the memory read data; the slave side is the engine.
interface me_sad_search_engine_if #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned BLK    = 16,
    parameter int unsigned SRCH   = 16,
    parameter int unsigned DIST_W = 16
);
    localparam int unsigned SW   = BLK + SRCH - 1;
    localparam int unsigned R_AW = (BLK * BLK > 1) ? $clog2(BLK * BLK) : 1;
    localparam int unsigned S_AW = (SW * SW > 1) ? $clog2(SW * SW) : 1;
    localparam int unsigned MV_W = (SRCH > 1) ? $clog2(SRCH) : 1;

    logic              start;
    logic              busy;
    logic              completed;
    logic [R_AW-1:0]   addr_r;
    logic [PIX_W-1:0]  r_data;
    logic [S_AW-1:0]   addr_s;
    logic [PIX_W-1:0]  s_data;
    logic [DIST_W-1:0] best_dist;
    logic [MV_W-1:0]   motion_x;
    logic [MV_W-1:0]   motion_y;

    modport master (
        output start, r_data, s_data,
        input  busy, completed, addr_r, addr_s, best_dist, motion_x, motion_y
    );

    modport slave (
        input  start, r_data, s_data,
        output busy, completed, addr_r, addr_s, best_dist, motion_x, motion_y
    );
endinterface

// File: rtl/me_sad_search_engine.sv
// Full-search block-matching motion estimator: one pixel per cycle, saturating SAD, earliest-minimum wins.
// Optional macro ME_EARLY_TERM_EN aborts a candidate as soon as its partial SAD reaches the current best.
module me_sad_search_engine #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned BLK    = 16,
    parameter int unsigned SRCH   = 16,
    parameter int unsigned DIST_W = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    me_sad_search_engine_if.slave bus
);
    localparam int unsigned SW    = BLK + SRCH - 1;
    localparam int unsigned R_AW  = (BLK * BLK > 1) ? $clog2(BLK * BLK) : 1;
    localparam int unsigned S_AW  = (SW * SW > 1) ? $clog2(SW * SW) : 1;
    localparam int unsigned MV_W  = (SRCH > 1) ? $clog2(SRCH) : 1;
    localparam int unsigned PC_W  = (BLK > 1) ? $clog2(BLK) : 1;
    localparam int unsigned SUM_W = DIST_W + 1;

    localparam logic [PC_W-1:0]   BLK_LAST = PC_W'(BLK - 1);
    localparam logic [MV_W-1:0]   MV_LAST  = MV_W'(SRCH - 1);
    localparam logic [DIST_W-1:0] DIST_MAX = {DIST_W{1'b1}};

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_CMP, S_DONE} state_e;

    typedef struct packed {
        logic [MV_W-1:0] y;
        logic [MV_W-1:0] x;
        logic [PC_W-1:0] i;
        logic [PC_W-1:0] j;
    } pos_t;

    typedef struct packed {
        logic            vld;
        logic            first_pix;
        logic            last_pix;
        logic [MV_W-1:0] mx;
        logic [MV_W-1:0] my;
    } meta_t;

    state_e            state_q, state_d;
    pos_t              pos_q, pos_d;
    meta_t             s1_q, s1_d, s2_q, s2_d;
    logic [DIST_W-1:0] acc_q, acc_d;
    logic [DIST_W-1:0] best_q, best_d;
    logic [MV_W-1:0]   bmx_q, bmx_d, bmy_q, bmy_d;
    logic              busy_q, busy_d;
    logic              completed_q, completed_d;
    logic [DIST_W-1:0] best_dist_q, best_dist_d;
    logic [MV_W-1:0]   motion_x_q, motion_x_d, motion_y_q, motion_y_d;
    logic [R_AW-1:0]   addr_r_q, addr_r_d;
    logic [S_AW-1:0]   addr_s_q, addr_s_d;

    logic              abort;
    logic              issue_en;
    pos_t              issue;
    logic [PIX_W-1:0]  diff;
    logic [SUM_W-1:0]  sum;

    // Scan order: j fastest, then i, then x, then y.
    function automatic pos_t pos_inc(input pos_t p);
        pos_t n;
        n = p;
        if (p.j != BLK_LAST) begin
            n.j = p.j + PC_W'(1);
        end else begin
            n.j = '0;
            if (p.i != BLK_LAST) begin
                n.i = p.i + PC_W'(1);
            end else begin
                n.i = '0;
                if (p.x != MV_LAST) begin
                    n.x = p.x + MV_W'(1);
                end else begin
                    n.x = '0;
                    n.y = p.y + MV_W'(1);
                end
            end
        end
        return n;
    endfunction

    function automatic logic pos_is_last(input pos_t p);
        return (p.j == BLK_LAST) && (p.i == BLK_LAST) && (p.x == MV_LAST) && (p.y == MV_LAST);
    endfunction

    function automatic logic [R_AW-1:0] r_addr(input pos_t p);
        return R_AW'(32'(p.i) * BLK + 32'(p.j));
    endfunction

    function automatic logic [S_AW-1:0] s_addr(input pos_t p);
        return S_AW'((32'(p.i) + 32'(p.y)) * SW + 32'(p.j) + 32'(p.x));
    endfunction

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        s1_d        = s1_q;
        s1_d.vld    = 1'b0;
        s2_d        = s1_q;
        acc_d       = acc_q;
        best_d      = best_q;
        bmx_d       = bmx_q;
        bmy_d       = bmy_q;
        busy_d      = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_CMP);
        completed_d = completed_q;
        best_dist_d = best_dist_q;
        motion_x_d  = motion_x_q;
        motion_y_d  = motion_y_q;
        addr_r_d    = addr_r_q;
        addr_s_d    = addr_s_q;
        abort       = 1'b0;
        issue_en    = 1'b1;
        issue       = pos_q;
        diff        = '0;
        sum         = '0;

        // Stage 2: accumulate the pixel returned by memory and close out finished candidates.
        if (s2_q.vld) begin
            diff  = (bus.r_data > bus.s_data) ? (bus.r_data - bus.s_data) : (bus.s_data - bus.r_data);
            sum   = SUM_W'(diff) + (s2_q.first_pix ? SUM_W'(0) : SUM_W'(acc_q));
            acc_d = sum[DIST_W] ? DIST_MAX : sum[DIST_W-1:0];
            if (s2_q.last_pix && (acc_d < best_q)) begin
                best_d = acc_d;
                bmx_d  = s2_q.mx;
                bmy_d  = s2_q.my;
            end
`ifdef ME_EARLY_TERM_EN
            abort = !s2_q.last_pix && !((s2_q.mx == '0) && (s2_q.my == '0)) && (acc_d >= best_q);
`endif
        end
        if (abort) begin
            s2_d.vld = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d     = S_RUN;
                    pos_d       = '0;
                    completed_d = 1'b0;
                    best_d      = DIST_MAX;
                    bmx_d       = '0;
                    bmy_d       = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    if ((s2_q.mx == MV_LAST) && (s2_q.my == MV_LAST)) begin
                        issue_en = 1'b0;
                        state_d  = S_DRAIN;
                    end else begin
                        issue   = '0;
                        issue.x = (s2_q.mx == MV_LAST) ? '0 : s2_q.mx + MV_W'(1);
                        issue.y = (s2_q.mx == MV_LAST) ? s2_q.my + MV_W'(1) : s2_q.my;
                    end
                end
                if (issue_en) begin
                    addr_r_d       = r_addr(issue);
                    addr_s_d       = s_addr(issue);
                    s1_d.vld       = 1'b1;
                    s1_d.first_pix = (issue.i == '0) && (issue.j == '0);
                    s1_d.last_pix  = (issue.i == BLK_LAST) && (issue.j == BLK_LAST);
                    s1_d.mx        = issue.x;
                    s1_d.my        = issue.y;
                    pos_d          = pos_inc(issue);
                    if (pos_is_last(issue)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: state_d = S_CMP;
            S_CMP:   state_d = S_DONE;
            S_DONE: begin
                state_d     = S_IDLE;
                completed_d = 1'b1;
                best_dist_d = best_q;
                motion_x_d  = bmx_q;
                motion_y_d  = bmy_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pos_q       <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            acc_q       <= '0;
            best_q      <= DIST_MAX;
            bmx_q       <= '0;
            bmy_q       <= '0;
            busy_q      <= 1'b0;
            completed_q <= 1'b0;
            best_dist_q <= DIST_MAX;
            motion_x_q  <= '0;
            motion_y_q  <= '0;
            addr_r_q    <= '0;
            addr_s_q    <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            acc_q       <= acc_d;
            best_q      <= best_d;
            bmx_q       <= bmx_d;
            bmy_q       <= bmy_d;
            busy_q      <= busy_d;
            completed_q <= completed_d;
            best_dist_q <= best_dist_d;
            motion_x_q  <= motion_x_d;
            motion_y_q  <= motion_y_d;
            addr_r_q    <= addr_r_d;
            addr_s_q    <= addr_s_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.completed = completed_q;
    assign bus.best_dist = best_dist_q;
    assign bus.motion_x  = motion_x_q;
    assign bus.motion_y  = motion_y_q;
    assign bus.addr_r    = addr_r_q;
    assign bus.addr_s    = addr_s_q;

endmodule

// File: tb/tb_me_sad_search_engine.sv
// Directed/randomised bench for me_sad_search_engine with a direct full-search SAD reference model.
module tb_me_sad_search_engine;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned BLK    = 4;
    localparam int unsigned SRCH   = 4;
    localparam int unsigned DIST_W = 10;
    localparam int          SW     = BLK + SRCH - 1;
    localparam int          N      = SRCH * SRCH * BLK * BLK;
    localparam int          DMAX   = (1 << DIST_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    me_sad_search_engine_if #(.PIX_W(PIX_W), .BLK(BLK), .SRCH(SRCH), .DIST_W(DIST_W)) bus ();

    me_sad_search_engine #(.PIX_W(PIX_W), .BLK(BLK), .SRCH(SRCH), .DIST_W(DIST_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] rmem [BLK*BLK];
    logic [7:0] smem [64];

    // Synchronous-read frame memories.
    always @(posedge clk) begin
        bus.r_data <= rmem[bus.addr_r];
        bus.s_data <= smem[bus.addr_s];
    end

    int tests = 0;
    int fails = 0;
    int prev_best = DMAX;
    int prev_mx   = 0;
    int prev_my   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ref_model(output int best, output int bx, output int by);
        best = DMAX; bx = 0; by = 0;
        for (int y = 0; y < SRCH; y++) begin
            for (int x = 0; x < SRCH; x++) begin
                int sad;
                sad = 0;
                for (int i = 0; i < BLK; i++) begin
                    for (int j = 0; j < BLK; j++) begin
                        int d;
                        d = int'(rmem[i*BLK+j]) - int'(smem[(i+y)*SW+j+x]);
                        sad += (d < 0) ? -d : d;
                    end
                end
                if (sad > DMAX) sad = DMAX;
                if (sad < best) begin best = sad; bx = x; by = y; end
            end
        end
    endtask

    task automatic fill(input int rmax, input int smax);
        for (int k = 0; k < BLK*BLK; k++) rmem[k] = 8'($urandom_range(rmax, 0));
        for (int k = 0; k < 64; k++)      smem[k] = 8'($urandom_range(smax, 0));
    endtask

    task automatic place_match(input int x, input int y);
        for (int i = 0; i < BLK; i++)
            for (int j = 0; j < BLK; j++)
                smem[(i+y)*SW+j+x] = rmem[i*BLK+j];
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int c = 1; c <= 4*N; c++) begin
            @(posedge clk); #1;
            if (bus.completed) begin dc = c; break; end
        end
    endtask

    task automatic run_search(input int pulse_at, output int dc, output int busy_cnt,
                              output int mid_best, output int mid_mx, output int mid_my);
        @(negedge clk); bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        check("completed_clr_on_start", 32'(bus.completed), 0);
        dc = -1; busy_cnt = 0; mid_best = -1; mid_mx = -1; mid_my = -1;
        for (int c = 1; c <= 4*N; c++) begin
            bus.start = (c == pulse_at);
            @(posedge clk); #1;
            if (c == 20) begin
                mid_best = int'(bus.best_dist); mid_mx = int'(bus.motion_x); mid_my = int'(bus.motion_y);
            end
            if (bus.completed) begin dc = c; break; end
            if (bus.busy) busy_cnt++;
        end
        bus.start = 1'b0;
    endtask

    task automatic search_and_check(input string name, input int pulse_at);
        int eb, ex, ey, dc, bc, mb, mx, my;
        ref_model(eb, ex, ey);
        run_search(pulse_at, dc, bc, mb, mx, my);
`ifdef ME_EARLY_TERM_EN
        check({name, "_latency_bound"}, 32'(dc > 0 && dc <= N + 3), 1);
        check({name, "_busy_cycles"}, bc, dc - 1);
`else
        check({name, "_latency"}, dc, N + 3);
        check({name, "_busy_cycles"}, bc, N + 2);
`endif
        check({name, "_busy_low_at_done"}, 32'(bus.busy), 0);
        check({name, "_best_dist"}, 32'(bus.best_dist), eb);
        check({name, "_motion_x"}, 32'(bus.motion_x), ex);
        check({name, "_motion_y"}, 32'(bus.motion_y), ey);
        check({name, "_hold_best_mid"}, mb, prev_best);
        check({name, "_hold_mv_mid"}, 32'(mx * 16 + my), prev_mx * 16 + prev_my);
        prev_best = eb; prev_mx = ex; prev_my = ey;
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_busy"}, 32'(bus.busy), 0);
        check({name, "_completed"}, 32'(bus.completed), 0);
        check({name, "_best_dist"}, 32'(bus.best_dist), DMAX);
        check({name, "_motion"}, 32'({bus.motion_x, bus.motion_y}), 0);
        check({name, "_addr_r"}, 32'(bus.addr_r), 0);
        check({name, "_addr_s"}, 32'(bus.addr_s), 0);
    endtask

    initial begin
        int eb, ex, ey, dc;
        bus.start = 1'b0;
        for (int k = 0; k < BLK*BLK; k++) rmem[k] = '0;
        for (int k = 0; k < 64; k++)      smem[k] = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Exact match planted at (1,2).
        fill(255, 255);
        place_match(1, 2);
        search_and_check("exact_match", 0);

        // Everything zero: all SADs tie at 0, the first candidate is kept.
        fill(0, 0);
        search_and_check("all_zero", 0);

        // Every SAD saturates at the accumulator limit.
        for (int k = 0; k < BLK*BLK; k++) rmem[k] = 8'd255;
        for (int k = 0; k < 64; k++)      smem[k] = 8'd0;
        search_and_check("saturate", 0);

        // Low-amplitude random data gives frequent near-ties.
        for (int n = 0; n < 3; n++) begin
            fill(15, 15);
            search_and_check("random_small", 0);
        end

        // A second start while busy must be ignored.
        fill(255, 255);
        place_match(3, 0);
        search_and_check("ignored_start", 10);
        repeat (5) @(posedge clk);
        #1;
        check("ignored_start_no_relaunch_busy", 32'(bus.busy), 0);
        check("ignored_start_completed_holds", 32'(bus.completed), 1);

        // Asynchronous reset in the middle of a search.
        fill(255, 255);
        @(negedge clk); bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        check_reset_values("midrun_reset");
        @(negedge clk); rst_n = 1'b1;
        prev_best = DMAX; prev_mx = 0; prev_my = 0;
        place_match(2, 3);
        search_and_check("after_reset", 0);

        // start held high re-launches as soon as the engine is back in IDLE.
        fill(255, 255);
        place_match(0, 1);
        ref_model(eb, ex, ey);
        @(negedge clk); bus.start = 1'b1;
        @(posedge clk); #1;
        wait_done(dc);
        check("held_first_done", 32'(dc > 0), 1);
        check("held_first_best", 32'(bus.best_dist), eb);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("held_relaunch_clears_completed", 32'(bus.completed), 0);
        @(posedge clk); #1;
        check("held_relaunch_busy", 32'(bus.busy), 1);
        wait_done(dc);
        check("held_second_done", 32'(dc > 0), 1);
        check("held_second_best", 32'(bus.best_dist), eb);
        check("held_second_motion", 32'({bus.motion_x, bus.motion_y}), 32'(ex * 4 + ey));
        prev_best = eb; prev_mx = ex; prev_my = ey;

        // Exact match at the very first candidate.
        fill(255, 255);
        place_match(0, 0);
        search_and_check("match_origin", 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
